// File: rtl/user_access_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the protected-register arbiter.
// Master drives requests; slave (the arbiter) returns registered pulses and status.
interface user_access_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] usr_id;
  logic [8*NUM_REQ-1:0] data_in;
  logic [7:0]           data_out;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   deny;
  logic [NUM_REQ-1:0]   locked;
  logic                 busy;
  logic [2:0]           grant_idx;

  modport master (
    output req, usr_id, data_in,
    input  data_out, ack, deny, locked, busy, grant_idx
  );

  modport slave (
    input  req, usr_id, data_in,
    output data_out, ack, deny, locked, busy, grant_idx
  );
endinterface

// File: rtl/user_access_arbiter.sv
// Round-robin guarded write of one 8-bit register; ack/deny 2 edges after req is sampled.
// Requests are level-held until ack/deny; losers simply wait, locked requesters are ignored.
module user_access_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter logic [2:0] AUTH_ID  = 3'h4,
  parameter int         MAX_FAIL = 3
) (
  input logic                  clk,
  input logic                  rst,
  user_access_arbiter_if.slave bus
);

  localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         id_q, id_d;
  logic [7:0]         dat_q, dat_d;
  logic [7:0]         out_q, out_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] deny_q, deny_d;
  logic [NUM_REQ-1:0] lock_q, lock_d;
  logic [2:0]         fail_q [NUM_REQ];
  logic [2:0]         fail_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic               pick_vld;
  logic [2:0]         pick_idx;
  logic [2:0]         fail_nxt;

  assign elig = bus.req & ~lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      dat_q   <= '0;
      out_q   <= '0;
      ack_q   <= '0;
      deny_q  <= '0;
      lock_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) fail_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      deny_q  <= deny_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    dat_d    = dat_q;
    out_d    = out_q;
    ack_d    = '0;
    deny_d   = '0;
    lock_d   = lock_q;
    fail_d   = fail_q;
    fail_nxt = '0;
    pick_vld = 1'b0;
    pick_idx = '0;

    // Wrapped indices (below ptr) are scanned first so the at-or-above-ptr pass overrides them.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (i < int'(ptr_q))) begin
        pick_vld = 1'b1;
        pick_idx = 3'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (i >= int'(ptr_q))) begin
        pick_vld = 1'b1;
        pick_idx = 3'(i);
      end
    end

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          state_d = CHECK;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(pick_idx)) begin
              id_d  = bus.usr_id[3*i +: 3];
              dat_d = bus.data_in[8*i +: 8];
            end
          end
        end
      end

      CHECK: begin
        state_d = DONE;
        ptr_d   = (int'(idx_q) == NUM_REQ - 1) ? 3'd0 : idx_q + 3'd1;
        if (id_q == AUTH_ID) out_d = dat_q;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == int'(idx_q)) begin
            if (id_q == AUTH_ID) begin
              ack_d[i]  = 1'b1;
              fail_d[i] = '0;
            end else begin
              deny_d[i] = 1'b1;
              fail_nxt  = (fail_q[i] < MAX_FAIL_C) ? fail_q[i] + 3'd1 : MAX_FAIL_C;
              fail_d[i] = fail_nxt;
              if (fail_nxt == MAX_FAIL_C) lock_d[i] = 1'b1;
            end
          end
        end
      end

      DONE: begin
        // Hold until the serviced request drops so a level-held req is not served twice.
        for (int i = 0; i < NUM_REQ; i++) begin
          if ((i == int'(idx_q)) && (!bus.req[i] || lock_q[i])) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out  = out_q;
  assign bus.ack       = ack_q;
  assign bus.deny      = deny_q;
  assign bus.locked    = lock_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_idx = (state_q == IDLE) ? 3'd0 : idx_q;

endmodule

// File: tb/tb_user_access_arbiter.sv
// Directed and random requests checked against a transaction-level model of the arbiter.
module tb_user_access_arbiter;
  localparam int         N    = 4;
  localparam logic [2:0] AUTH = 3'h4;
  localparam int         MAXF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]   m_out;
  logic [N-1:0] m_lock;
  int           m_ptr;
  int           m_fail[$];

  user_access_arbiter_if #(.NUM_REQ(N)) bus ();

  user_access_arbiter #(
    .NUM_REQ (N),
    .AUTH_ID (AUTH),
    .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out  = '0;
    m_lock = '0;
    m_ptr  = 0;
    m_fail.delete();
    for (int k = 0; k < N; k++) m_fail.push_back(0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    chk("rst_data_out", 32'(bus.data_out), 32'(0));
    chk("rst_ack", 32'(bus.ack), 32'(0));
    chk("rst_deny", 32'(bus.deny), 32'(0));
    chk("rst_locked", 32'(bus.locked), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_grant_idx", 32'(bus.grant_idx), 32'(0));
  endtask

  // Serve every eligible request in the mask; the model decides the order and outcome.
  task automatic run_round(input logic [N-1:0] mask, input logic [3*N-1:0] ids,
                           input logic [8*N-1:0] dats);
    logic [N-1:0] pend, tmp, eack, edeny, wbit;
    logic [2:0]   wid;
    logic [7:0]   wdat;
    int           w, c, lat;
    bit           seen;
    bus.usr_id  = ids;
    bus.data_in = dats;
    bus.req     = mask;
    pend        = mask & ~m_lock;
    while (pend != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c   = (m_ptr + k) % N;
        tmp = pend >> c;
        if (w < 0 && tmp[0]) w = c;
      end
      wbit  = N'(1) << w;
      wid   = 3'(ids >> (3 * w));
      wdat  = 8'(dats >> (8 * w));
      eack  = '0;
      edeny = '0;
      if (wid == AUTH) begin
        m_out     = wdat;
        m_fail[w] = 0;
        eack      = wbit;
      end else begin
        edeny = wbit;
        if (m_fail[w] < MAXF) m_fail[w] = m_fail[w] + 1;
        if (m_fail[w] == MAXF) m_lock = m_lock | wbit;
      end
      m_ptr = (w + 1) % N;

      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 8) begin
        tick();
        lat++;
        if ((bus.ack | bus.deny) != '0) seen = 1'b1;
        else if (bus.busy) begin
          chk("grant_idx_check", 32'(bus.grant_idx), 32'(w));
          // Once latched, the winner's inputs must no longer matter.
          bus.usr_id  = bus.usr_id ^ ((3*N)'(7) << (3 * w));
          bus.data_in = bus.data_in ^ ((8*N)'(8'hFF) << (8 * w));
        end
      end
      chk("pulse_seen", 32'(seen), 32'(1));
      chk("latency", 32'(lat), 32'(2));
      chk("ack", 32'(bus.ack), 32'(eack));
      chk("deny", 32'(bus.deny), 32'(edeny));
      chk("data_out", 32'(bus.data_out), 32'(m_out));
      chk("locked", 32'(bus.locked), 32'(m_lock));
      chk("busy_done", 32'(bus.busy), 32'(1));
      chk("grant_idx_done", 32'(bus.grant_idx), 32'(w));
      // A freshly locked requester keeps req high: the arbiter must still go idle.
      if ((m_lock & wbit) == '0) bus.req = bus.req & ~wbit;
      pend = pend & ~wbit;
      tick();
      chk("pulse_end", 32'(bus.ack | bus.deny), 32'(0));
      chk("idle_after", 32'(bus.busy), 32'(0));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("quiet_busy", 32'(bus.busy), 32'(0));
      chk("quiet_pulse", 32'(bus.ack | bus.deny), 32'(0));
    end
    bus.req = '0;
  endtask

  initial begin
    logic [N-1:0]   rmask;
    logic [3*N-1:0] rids;
    logic [8*N-1:0] rdat;
    bus.req     = '0;
    bus.usr_id  = '0;
    bus.data_in = '0;
    model_reset();
    do_reset();

    run_round(4'b0001, {9'd0, 3'd4}, {24'd0, 8'hA5});
    run_round(4'b0010, {6'd0, 3'd3, 3'd0}, {16'd0, 8'h5A, 8'h00});
    for (int k = 0; k < 3; k++) run_round(4'b0100, {3'd0, 3'd1, 6'd0}, {8'h00, 8'h77, 16'h0});
    chk("lock2_set", 32'(bus.locked[2]), 32'(1));
    run_round(4'b0100, {3'd0, 3'd4, 6'd0}, {8'h00, 8'h99, 16'h0});
    chk("lock2_out_unchanged", 32'(bus.data_out), 32'(8'hA5));

    do_reset();
    run_round(4'b1111, {3'd4, 3'd4, 3'd4, 3'd4}, {8'h13, 8'h12, 8'h11, 8'h10});
    chk("rr_final_out", 32'(bus.data_out), 32'(8'h13));
    run_round(4'b0010, {3'd0, 3'd0, 3'd4, 3'd0}, {8'h00, 8'h00, 8'h21, 8'h00});
    run_round(4'b1111, {3'd4, 3'd4, 3'd4, 3'd4}, {8'h13, 8'h12, 8'h11, 8'h10});
    chk("rr2_final_out", 32'(bus.data_out), 32'(8'h11));

    // Reset landing while the arbiter is in CHECK.
    do_reset();
    run_round(4'b0001, {9'd0, 3'd4}, {24'd0, 8'h77});
    bus.usr_id  = {6'd0, 3'd4, 3'd0};
    bus.data_in = {16'd0, 8'hFF, 8'h00};
    bus.req     = 4'b0010;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'(1));
    chk("mid_grant_idx", 32'(bus.grant_idx), 32'(1));
    rst = 1'b1;
    tick();
    chk("abort_ack", 32'(bus.ack), 32'(0));
    chk("abort_deny", 32'(bus.deny), 32'(0));
    chk("abort_data_out", 32'(bus.data_out), 32'(0));
    chk("abort_busy", 32'(bus.busy), 32'(0));
    rst = 1'b0;
    model_reset();
    run_round(4'b0010, {6'd0, 3'd4, 3'd0}, {16'd0, 8'hFF, 8'h00});

    // A grant between denials restarts the consecutive-fail count.
    do_reset();
    for (int k = 0; k < 2; k++) run_round(4'b1000, {3'd2, 9'd0}, {8'h31, 24'd0});
    run_round(4'b1000, {3'd4, 9'd0}, {8'h32, 24'd0});
    for (int k = 0; k < 2; k++) run_round(4'b1000, {3'd2, 9'd0}, {8'h33, 24'd0});
    chk("lock3_clear", 32'(bus.locked[3]), 32'(0));

    for (int r = 0; r < 40; r++) begin
      if (r % 10 == 0) do_reset();
      rmask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        rids[3*k +: 3] = ($urandom_range(0, 1) == 0) ? AUTH : 3'($urandom_range(0, 7));
      end
      rdat = (8*N)'($urandom);
      run_round(rmask, rids, rdat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
